// File: rtl/pc060ha_slave_port.sv
// PC060HA sound-CPU responder port: mailbox nibble access, full flags, NMI.
// Latency: reads land in DOUT one CLK after the strobe edge; flags/NMI are registered.
module pc060ha_slave_port #(
    parameter int NIBBLES = 4,
    parameter int IDX_W   = 3
) (
    input  logic                 CLK,
    input  logic                 nRESET,
    input  logic                 CS_n,
    input  logic                 RD_n,
    input  logic                 WR_n,
    input  logic                 A0,
    input  logic [3:0]           DIN,
    output logic [3:0]           DOUT,
    input  logic [4*NIBBLES-1:0] M2S_DATA,
    input  logic                 M2S_SET,
    input  logic                 S2M_ACK,
    output logic [4*NIBBLES-1:0] S2M_DATA,
    output logic                 M2S_FULL,
    output logic                 S2M_FULL,
    output logic                 NMI_n
);

    localparam int OFS_W = $clog2(4 * NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NIBBLES - 1);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_NMI_ON = IDX_W'(NIBBLES + 1);
    localparam logic [IDX_W-1:0] IDX_NMI_OF = IDX_W'(NIBBLES + 2);

    logic [IDX_W-1:0]       idx_q, idx_d, idx_inc;
    logic [3:0]             dout_q, dout_d;
    logic [4*NIBBLES-1:0]   s2m_q, s2m_d;
    logic                   m2s_full_q, m2s_full_d;
    logic                   s2m_full_q, s2m_full_d;
    logic                   nmi_en_q, nmi_en_d;
    logic                   nmi_n_q, nmi_n_d;
    logic                   rd_act_q, wr_act_q;
    logic                   rd_act, wr_act, rd_fire, wr_fire;
    logic                   nib_sel, m2s_clr, s2m_set;
    logic [OFS_W-1:0]       ofs;

    always_comb begin
        rd_act  = ~CS_n & ~RD_n;
        wr_act  = ~CS_n & ~WR_n;
        wr_fire = wr_act & ~wr_act_q;
        // a simultaneous write wins over the read
        rd_fire = rd_act & ~rd_act_q & ~wr_fire;
        nib_sel = (idx_q <= IDX_LAST);
        idx_inc = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        ofs     = {idx_q[OFS_W-3:0], 2'b00};

        idx_d    = idx_q;
        dout_d   = dout_q;
        s2m_d    = s2m_q;
        nmi_en_d = nmi_en_q;
        m2s_clr  = 1'b0;
        s2m_set  = 1'b0;

        if (wr_fire) begin
            if (!A0) begin
                idx_d = DIN[IDX_W-1:0];
            end else if (nib_sel) begin
                s2m_d[ofs +: 4] = DIN;
                s2m_set         = (idx_q == IDX_LAST);
                idx_d           = idx_inc;
            end else if (idx_q == IDX_NMI_ON) begin
                nmi_en_d = 1'b1;
            end else if (idx_q == IDX_NMI_OF) begin
                nmi_en_d = 1'b0;
            end
        end else if (rd_fire) begin
            if (!A0) begin
                dout_d = 4'(idx_q);
            end else if (nib_sel) begin
                dout_d  = M2S_DATA[ofs +: 4];
                m2s_clr = (idx_q == IDX_LAST);
                idx_d   = idx_inc;
            end else if (idx_q == IDX_STATUS) begin
                dout_d = {2'b00, s2m_full_q, m2s_full_q};
            end else begin
                dout_d = 4'h0;
            end
        end

        // set beats clear: fresh data must not be lost
        m2s_full_d = M2S_SET | (m2s_full_q & ~m2s_clr);
        s2m_full_d = s2m_set | (s2m_full_q & ~S2M_ACK);
        nmi_n_d    = ~(nmi_en_q & m2s_full_q);
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            idx_q      <= '0;
            dout_q     <= '0;
            s2m_q      <= '0;
            m2s_full_q <= 1'b0;
            s2m_full_q <= 1'b0;
            nmi_en_q   <= 1'b0;
            nmi_n_q    <= 1'b1;
            rd_act_q   <= 1'b0;
            wr_act_q   <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            dout_q     <= dout_d;
            s2m_q      <= s2m_d;
            m2s_full_q <= m2s_full_d;
            s2m_full_q <= s2m_full_d;
            nmi_en_q   <= nmi_en_d;
            nmi_n_q    <= nmi_n_d;
            rd_act_q   <= rd_act;
            wr_act_q   <= wr_act;
        end
    end

    assign DOUT     = dout_q;
    assign S2M_DATA = s2m_q;
    assign M2S_FULL = m2s_full_q;
    assign S2M_FULL = s2m_full_q;
    assign NMI_n    = nmi_n_q;

endmodule

// File: tb/tb_pc060ha_slave_port.sv
// Bench for pc060ha_slave_port: directed steps plus random bus traffic against a
// transaction-level model of the mailbox rules.
module tb_pc060ha_slave_port;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic        CS_n, RD_n, WR_n, A0;
    logic [3:0]  DIN;
    logic [3:0]  DOUT;
    logic [15:0] M2S_DATA;
    logic        M2S_SET, S2M_ACK;
    logic [15:0] S2M_DATA;
    logic        M2S_FULL, S2M_FULL, NMI_n;

    int checks = 0;
    int failures = 0;

    // reference model state
    int         m_idx;
    logic [3:0] m_dout;
    int         m_s2m [4];
    logic       m_m2s_full, m_s2m_full, m_nmi_en, m_nmi_n;
    logic       m_rd_prev, m_wr_prev;

    pc060ha_slave_port #(.NIBBLES(4), .IDX_W(3)) dut (
        .CLK(CLK), .nRESET(nRESET), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n),
        .A0(A0), .DIN(DIN), .DOUT(DOUT), .M2S_DATA(M2S_DATA), .M2S_SET(M2S_SET),
        .S2M_ACK(S2M_ACK), .S2M_DATA(S2M_DATA), .M2S_FULL(M2S_FULL),
        .S2M_FULL(S2M_FULL), .NMI_n(NMI_n)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_s2m();
        logic [15:0] w = 16'h0;
        for (int i = 0; i < 4; i++) w = w | 16'(m_s2m[i] << (4 * i));
        return w;
    endfunction

    task automatic model_reset();
        m_idx = 0; m_dout = 4'h0;
        for (int i = 0; i < 4; i++) m_s2m[i] = 0;
        m_m2s_full = 0; m_s2m_full = 0; m_nmi_en = 0; m_nmi_n = 1;
        m_rd_prev = 0; m_wr_prev = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".dout"}, 16'(DOUT), 16'(m_dout));
        chk({tag, ".s2m"}, S2M_DATA, exp_s2m());
        chk({tag, ".m2s_full"}, 16'(M2S_FULL), 16'(m_m2s_full));
        chk({tag, ".s2m_full"}, 16'(S2M_FULL), 16'(m_s2m_full));
        chk({tag, ".nmi_n"}, 16'(NMI_n), 16'(m_nmi_n));
    endtask

    // One CLK: drive inputs, step the model by the mailbox rules, compare.
    task automatic cycle(input logic cs, input logic rd, input logic wr, input logic a0,
                         input logic [3:0] din, input logic set, input logic ack);
        logic rd_a, wr_a, rf, wf, nmi_next, clr, sset;
        CS_n = cs; RD_n = rd; WR_n = wr; A0 = a0; DIN = din;
        M2S_SET = set; S2M_ACK = ack;
        rd_a = !cs && !rd;
        wr_a = !cs && !wr;
        wf = wr_a && !m_wr_prev;
        rf = rd_a && !m_rd_prev && !wf;
        m_rd_prev = rd_a; m_wr_prev = wr_a;
        nmi_next = !(m_nmi_en && m_m2s_full);
        @(posedge CLK); #1;
        m_nmi_n = nmi_next;
        clr = 0; sset = 0;
        if (wf) begin
            if (!a0) m_idx = int'(din) & 7;
            else if (m_idx < 4) begin
                m_s2m[m_idx] = int'(din);
                sset = (m_idx == 3);
                m_idx = (m_idx + 1) % 4;
            end else if (m_idx == 5) m_nmi_en = 1;
            else if (m_idx == 6) m_nmi_en = 0;
        end else if (rf) begin
            if (!a0) m_dout = 4'(m_idx);
            else if (m_idx < 4) begin
                m_dout = 4'((M2S_DATA >> (4 * m_idx)) & 16'hF);
                clr = (m_idx == 3);
                m_idx = (m_idx + 1) % 4;
            end else if (m_idx == 4) m_dout = {2'b00, m_s2m_full, m_m2s_full};
            else m_dout = 4'h0;
        end
        m_m2s_full = set || (m_m2s_full && !clr);
        m_s2m_full = sset || (m_s2m_full && !ack);
        check_outputs("cyc");
    endtask

    task automatic idle();
        cycle(1, 1, 1, 0, 4'h0, 0, 0);
    endtask

    task automatic wr_acc(input logic a0, input logic [3:0] d);
        cycle(0, 1, 0, a0, d, 0, 0);
        idle();
    endtask

    task automatic rd_acc(input logic a0);
        cycle(0, 0, 1, a0, 4'h0, 0, 0);
        idle();
    endtask

    initial begin
        nRESET = 0; CS_n = 1; RD_n = 1; WR_n = 1; A0 = 0; DIN = 0;
        M2S_DATA = 16'h0; M2S_SET = 0; S2M_ACK = 0;
        model_reset();
        #12;
        chk("rst.dout", 16'(DOUT), 16'h0);
        chk("rst.s2m", S2M_DATA, 16'h0000);
        chk("rst.m2s_full", 16'(M2S_FULL), 16'h0);
        chk("rst.s2m_full", 16'(S2M_FULL), 16'h0);
        chk("rst.nmi_n", 16'(NMI_n), 16'h1);
        @(negedge CLK); nRESET = 1;
        idle();

        // master mail, NMI enable, four reads
        M2S_DATA = 16'hA5C3;
        cycle(1, 1, 1, 0, 4'h0, 1, 0);
        idle();
        wr_acc(0, 4'd5);
        cycle(0, 1, 0, 1, 4'h0, 0, 0);
        chk("nmi.before", 16'(NMI_n), 16'h1);
        idle();
        chk("nmi.asserted", 16'(NMI_n), 16'h0);
        wr_acc(0, 4'd0);
        rd_acc(1); chk("rd0", 16'(DOUT), 16'h3);
        rd_acc(1); chk("rd1", 16'(DOUT), 16'hC);
        rd_acc(1); chk("rd2", 16'(DOUT), 16'h5);
        cycle(0, 0, 1, 1, 4'h0, 0, 0);
        chk("rd3", 16'(DOUT), 16'hA);
        chk("rd3.m2s_full", 16'(M2S_FULL), 16'h0);
        idle();
        chk("rd3.nmi_n", 16'(NMI_n), 16'h1);
        rd_acc(0); chk("idx.wrap", 16'(DOUT), 16'h0);

        // slave reply
        wr_acc(0, 4'd0);
        wr_acc(1, 4'd1); wr_acc(1, 4'd2); wr_acc(1, 4'd3);
        chk("s2m_full.early", 16'(S2M_FULL), 16'h0);
        cycle(0, 1, 0, 1, 4'd4, 0, 0);
        chk("s2m_full.set", 16'(S2M_FULL), 16'h1);
        chk("s2m.data", S2M_DATA, 16'h4321);
        idle();
        wr_acc(0, 4'd4);
        rd_acc(1); chk("status", 16'(DOUT), 16'h2);
        cycle(1, 1, 1, 0, 4'h0, 0, 1);
        chk("ack", 16'(S2M_FULL), 16'h0);

        // held strobe fires once
        wr_acc(0, 4'd0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 1, 4'h0, 0, 0);
        idle();
        rd_acc(0); chk("held.idx", 16'(DOUT), 16'h1);

        // set/clear collisions
        wr_acc(0, 4'd3);
        cycle(1, 1, 1, 0, 4'h0, 1, 0);
        cycle(0, 0, 1, 1, 4'h0, 1, 0);
        chk("m2s.set_wins", 16'(M2S_FULL), 16'h1);
        idle();
        wr_acc(0, 4'd3);
        cycle(0, 1, 0, 1, 4'h7, 0, 1);
        chk("s2m.set_wins", 16'(S2M_FULL), 16'h1);
        idle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) M2S_DATA = 16'($urandom);
            cycle(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), logic'($urandom_range(0, 7) == 0),
                  logic'($urandom_range(0, 7) == 0));
        end
        idle();

        // async reset mid-sequence with idx=2, S2M_FULL=1, nmi_en=1
        wr_acc(0, 4'd5); wr_acc(1, 4'd0);
        wr_acc(0, 4'd3); wr_acc(1, 4'd9);
        wr_acc(0, 4'd2);
        cycle(1, 1, 1, 0, 4'h0, 1, 0);
        idle(); idle();
        chk("pre_rst.s2m_full", 16'(S2M_FULL), 16'h1);
        chk("pre_rst.nmi_n", 16'(NMI_n), 16'h0);
        CS_n = 0; RD_n = 0; A0 = 1;
        nRESET = 0;
        #2;
        model_reset();
        chk("arst.dout", 16'(DOUT), 16'h0);
        chk("arst.s2m", S2M_DATA, 16'h0000);
        chk("arst.m2s_full", 16'(M2S_FULL), 16'h0);
        chk("arst.s2m_full", 16'(S2M_FULL), 16'h0);
        chk("arst.nmi_n", 16'(NMI_n), 16'h1);
        M2S_DATA = 16'h00B0 | 16'h0006;
        @(negedge CLK); nRESET = 1;
        cycle(0, 0, 1, 1, 4'h0, 0, 0);
        chk("rel.read", 16'(DOUT), 16'h6);
        idle();
        rd_acc(0); chk("rel.idx", 16'(DOUT), 16'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
